// File: rtl/controle_varredura_servo.sv
// Radar sweep sequencer feeding circuito_pwm.
// Walks the servo back and forth over 0..POS_MAX. At every position it waits
// for the servo to settle, requests one measurement, waits for the answer (or
// gives up after a timeout) and then steps one position. A shadow copy of the
// servo position is kept so the bounce decision needs no feedback from the PWM
// block.
//
// Handshake with neighbours: set_pos, direita, esquerda and medir are
// single-cycle strobes, each high for exactly the one cycle spent in its
// state; pronto_medida is a pulse that is only looked at while waiting for a
// measurement and is ignored everywhere else.
module controle_varredura_servo #(
  parameter int unsigned T_DWELL   = 25_000_000,
  parameter int unsigned T_TIMEOUT = 50_000_000,
  parameter int unsigned POS_MAX   = 3,
  parameter int unsigned POS_INI   = 0
) (
  input  logic       clock,
  input  logic       zera,
  input  logic       iniciar,
  input  logic       parar,
  input  logic       pronto_medida,
  output logic       set_pos,
  output logic [1:0] pos_inicial,
  output logic       direita,
  output logic       esquerda,
  output logic       medir,
  output logic [1:0] posicao,
  output logic       sentido,
  output logic       erro_medida,
  output logic       ativo,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    CARREGA = 3'd1,
    ESPERA  = 3'd2,
    MEDE    = 3'd3,
    AGUARDA = 3'd4,
    DECIDE  = 3'd5,
    MOVE    = 3'd6
  } estado_t;

  localparam logic [1:0]  POS_MAX_L   = POS_MAX[1:0];
  localparam logic [1:0]  POS_INI_L   = POS_INI[1:0];
  localparam logic [31:0] DWELL_FIM   = 32'(T_DWELL - 1);
  localparam logic [31:0] TIMEOUT_FIM = 32'(T_TIMEOUT - 1);

  estado_t     estado;
  estado_t     proximo;
  logic [31:0] cnt_dwell;
  logic [31:0] cnt_timeout;
  logic        passo_sobe;   // direction chosen in DECIDE, used in MOVE

  logic fim_dwell;
  logic estourou;
  logic vira_desce;
  logic vira_sobe;

  assign fim_dwell  = (cnt_dwell == DWELL_FIM);
  assign estourou   = (cnt_timeout == TIMEOUT_FIM);
  assign vira_desce = sentido && (posicao == POS_MAX_L);
  assign vira_sobe  = !sentido && (posicao == 2'd0);

  // State register.
  always_ff @(posedge clock or posedge zera) begin
    if (zera) begin
      estado <= INICIAL;
    end else begin
      estado <= proximo;
    end
  end

  // Next-state logic; parar wins over everything and, in MOVE, only takes
  // effect after the step pulse has been issued.
  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL: begin
        if (iniciar && !parar) proximo = CARREGA;
      end
      CARREGA: begin
        proximo = parar ? INICIAL : ESPERA;
      end
      ESPERA: begin
        if (parar)          proximo = INICIAL;
        else if (fim_dwell) proximo = MEDE;
      end
      MEDE: begin
        proximo = parar ? INICIAL : AGUARDA;
      end
      AGUARDA: begin
        if (parar)                          proximo = INICIAL;
        else if (pronto_medida || estourou) proximo = DECIDE;
      end
      DECIDE: begin
        proximo = parar ? INICIAL : MOVE;
      end
      MOVE: begin
        proximo = parar ? INICIAL : ESPERA;
      end
      default: begin
        proximo = INICIAL;
      end
    endcase
  end

  // Settle counter: runs only while staying in ESPERA, zero otherwise.
  always_ff @(posedge clock or posedge zera) begin
    if (zera) begin
      cnt_dwell <= '0;
    end else if (estado == ESPERA && proximo == ESPERA) begin
      cnt_dwell <= cnt_dwell + 32'd1;
    end else begin
      cnt_dwell <= '0;
    end
  end

  // Measurement timeout counter: runs only while staying in AGUARDA.
  always_ff @(posedge clock or posedge zera) begin
    if (zera) begin
      cnt_timeout <= '0;
    end else if (estado == AGUARDA && proximo == AGUARDA) begin
      cnt_timeout <= cnt_timeout + 32'd1;
    end else begin
      cnt_timeout <= '0;
    end
  end

  // Shadow position, direction and error flag. The load in CARREGA and the
  // step in MOVE always happen because the matching strobe has already been
  // seen by circuito_pwm in that cycle.
  always_ff @(posedge clock or posedge zera) begin
    if (zera) begin
      posicao     <= POS_INI_L;
      sentido     <= 1'b1;
      erro_medida <= 1'b0;
      passo_sobe  <= 1'b1;
    end else begin
      case (estado)
        CARREGA: begin
          posicao     <= POS_INI_L;
          sentido     <= 1'b1;
          erro_medida <= 1'b0;
        end
        AGUARDA: begin
          if (!parar && !pronto_medida && estourou) erro_medida <= 1'b1;
        end
        DECIDE: begin
          if (!parar) begin
            if (vira_desce) begin
              sentido    <= 1'b0;
              passo_sobe <= 1'b0;
            end else if (vira_sobe) begin
              sentido    <= 1'b1;
              passo_sobe <= 1'b1;
            end else begin
              passo_sobe <= sentido;
            end
          end
        end
        MOVE: begin
          if (passo_sobe) posicao <= posicao + 2'd1;
          else            posicao <= posicao - 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    set_pos   = (estado == CARREGA);
    medir     = (estado == MEDE);
    direita   = (estado == MOVE) && passo_sobe;
    esquerda  = (estado == MOVE) && !passo_sobe;
    ativo     = (estado != INICIAL);
    db_estado = estado;
  end

  assign pos_inicial = POS_INI_L;

endmodule
